// File: rtl/move_controller.sv
// move_controller: takes a position select and an Enter press and produces a
// single-cycle one-hot Sel strobe for the nine board cells, plus a stable Turn
// flag. It rejects illegal moves, alternates turns and counts committed moves.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | waiting for an Enter press edge; Ready is high only here
// CHECK    | latched position validated against Board, GameOver, MoveCount
// COMMIT   | Sel strobe high for this one cycle; Turn still the mover's symbol
// WAIT_REL | waiting for Enter release before another press is accepted
module move_controller #(
  parameter bit FIRST_TURN = 1'b0
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Enter,
  input  logic [3:0]  Pos,
  input  logic [17:0] Board,
  input  logic        GameOver,
  output logic [8:0]  Sel,
  output logic        Turn,
  output logic        Illegal,
  output logic [3:0]  MoveCount,
  output logic        Full,
  output logic        Ready
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    COMMIT   = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CELL = 4'd8;
  localparam logic [3:0] MAX_MOVES = 4'd9;

  state_t      state_q, state_d;
  logic        en_q;
  logic        rise;
  logic [3:0]  pos_q, pos_d;
  logic [8:0]  sel_q, sel_d;
  logic        turn_q, turn_d;
  logic        illegal_q, illegal_d;
  logic [3:0]  count_q, count_d;
  logic [1:0]  cell_state;
  logic        legal;

  assign rise = Enter & ~en_q;

  // Enter history; resets high so a button held through reset is not a press.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      en_q <= 1'b1;
    end else begin
      en_q <= Enter;
    end
  end

  // State of the latched cell; positions beyond 8 read as empty here but are
  // rejected by the range term of the legality check.
  always_comb begin
    cell_state = 2'b00;
    for (int i = 0; i < 9; i++) begin
      if (pos_q == 4'(i)) begin
        cell_state = Board[2*i +: 2];
      end
    end
  end

  assign legal = (pos_q <= LAST_CELL) &&
                 (cell_state == 2'b00) &&
                 !GameOver &&
                 (count_q < MAX_MOVES);

  // Next-state and datapath decisions; Sel and Illegal default low so each is
  // a single-cycle pulse.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    sel_d     = '0;
    turn_d    = turn_q;
    illegal_d = 1'b0;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          pos_d   = Pos;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (legal) begin
          sel_d   = 9'd1 << pos_q;
          state_d = COMMIT;
        end else begin
          illegal_d = 1'b1;
          state_d   = WAIT_REL;
        end
      end
      COMMIT: begin
        // The in-flight move completes even if GameOver rises now.
        turn_d = ~turn_q;
        if (count_q < MAX_MOVES) begin
          count_d = count_q + 4'd1;
        end
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (!Enter) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any move in flight.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      sel_q     <= '0;
      turn_q    <= FIRST_TURN;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      sel_q     <= sel_d;
      turn_q    <= turn_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign Sel       = sel_q;
  assign Turn      = turn_q;
  assign Illegal   = illegal_q;
  assign MoveCount = count_q;
  assign Full      = (count_q == MAX_MOVES);
  assign Ready     = (state_q == IDLE);

endmodule

// File: doc/move_controller.md
# move_controller

Upstream stage of the nine board cells. It turns a player's position select and Enter press into a single-cycle one-hot `Sel` strobe plus a stable `Turn` flag. It rejects illegal moves: an occupied cell, an out-of-range position, a finished game or a full board. It alternates turns and counts committed moves. Each cell's `Sel` input connects to one bit of `Sel`, and every cell shares the `Turn` line.

## Interface
- `FIRST_TURN`, default 0: value of `Turn` after reset. 0 means X moves first, 1 means O moves first.
- `clk`, in, 1: clock.
- `Reset`, in, 1: asynchronous, active-high reset.
- `Enter`, in, 1: move-confirm button. Level input, already synchronous and debounced.
- `Pos`, in, 4: target cell index, 0..8, row-major. Values 9..15 are illegal.
- `Board`, in, 18: cell states. `Board[2i+1:2i]` is the state of cell i: 00 empty, 01 X, 11 O.
- `GameOver`, in, 1: level from the win checker. 1 blocks all further moves.
- `Sel`, out, 9: one-hot commit strobe to the cells. Registered.
- `Turn`, out, 1: current player. 0 = X, 1 = O. Registered.
- `Illegal`, out, 1: one-cycle pulse when a move is rejected. Registered.
- `MoveCount`, out, 4: number of committed moves, 0..9.
- `Full`, out, 1: high when `MoveCount` = 9.
- `Ready`, out, 1: high in IDLE only.

## Operation
- The block keeps a registered copy of Enter, `en_q`. A press edge is `rise` = `Enter & ~en_q`.
- `en_q` resets to 1. A button held through reset therefore does not produce a move.
- FSM states: IDLE, CHECK, COMMIT, WAIT_REL.
- IDLE:
  - On `rise`, latch `Pos` into `pos_q` and go to CHECK.
  - Otherwise stay in IDLE.
- CHECK: the move is legal when all of the following hold:
  - `pos_q` ≤ 8;
  - `Board[2*pos_q+1:2*pos_q]` = 00;
  - `GameOver` = 0;
  - `MoveCount` < 9.
- CHECK outcome:
  - Legal: set `Sel` ← one-hot(`pos_q`) and go to COMMIT.
  - Illegal: set `Illegal` ← 1 and go to WAIT_REL.
- COMMIT:
  - `Sel` is high for exactly this cycle. `Turn` is unchanged during it, so the selected cell captures the correct symbol at the end of the cycle.
  - On exit: clear `Sel`, toggle `Turn`, increment `MoveCount`, go to WAIT_REL.
- WAIT_REL:
  - `Illegal` is cleared on entry, so its pulse lasts one cycle.
  - Go to IDLE when sampled `Enter` = 0. Holding Enter never causes a second move.
- `Turn` toggles only on a committed move. A rejected move leaves the same player to play.
- `MoveCount` saturates at 9 and never wraps. `Full` is 1 exactly when `MoveCount` = 9.
- Changes to `Pos` after the latch in IDLE are ignored for that press.
- `Board` is evaluated only in CHECK.

## Timing
- Reset values: `Sel` = 0, `Turn` = `FIRST_TURN`, `Illegal` = 0, `MoveCount` = 0, `Full` = 0, `Ready` = 1, state IDLE, `en_q` = 1, `pos_q` = 0.
- Latency, counting the edge that samples `rise` as edge 0:
  - CHECK occupies the cycle after edge 0.
  - `Sel` is high in the cycle after edge 1.
  - The cell state updates at edge 2.
  - `Turn` and `MoveCount` update at edge 2, visible in the same cycle as the new `Board` value.
  - `Illegal` is high in the cycle after edge 1.
- `Sel` is never high for more than one cycle and never has more than one bit set.
- `Ready` is low from edge 0 until return to IDLE.
- `Sel` is 0 whenever `Illegal` is 1.
- A `GameOver` rise during COMMIT does not cancel the in-flight move.
- `Reset` asserted in any state:
  - immediately clears `Sel` and aborts the move;
  - no cell is written after reset release until a new press edge.
- The `Reset` line is shared with the cells, so the board and this block clear together.
- Enter released and re-pressed while in CHECK or COMMIT: the cycle-level press is not counted. A new edge is recognised only from IDLE.

## Test plan
- Legal move:
  - Stimulus: reset, `FIRST_TURN` = 0, `Board` = 0, `Pos` = 4, Enter high for 5 cycles.
  - Response: `Sel` = 9'h010 for exactly 1 cycle, 2 cycles after the rising edge, with `Turn` = 0. Then `Turn` = 1, `MoveCount` = 1. No further `Sel` until Enter is released and pressed again.
- Occupied cell:
  - Stimulus: `Board[9:8]` = 01, `Pos` = 4, press.
  - Response: `Illegal` high for 1 cycle, `Sel` stays 0, `Turn` and `MoveCount` unchanged.
- Out of range:
  - Stimulus: `Pos` = 9, then `Pos` = 15, one press each.
  - Response: `Illegal` pulse for each press, no `Sel`.
- Game over and full board:
  - Stimulus: `GameOver` = 1 with a legal `Pos`, press.
  - Response: `Illegal` pulse.
  - Stimulus: play 9 legal alternating moves.
  - Response: `Sel` bits follow the chosen `Pos` values, `Turn` alternates 0,1,…,0, `MoveCount` = 9, `Full` = 1. A 10th press gives `Illegal`.
- Reset mid-move:
  - Stimulus: assert `Reset` during CHECK, release it while Enter is still held.
  - Response: `Sel` stays 0 throughout, `MoveCount` = 0, no move occurs until Enter goes low and then high again.
- `FIRST_TURN` = 1:
  - Stimulus: set `FIRST_TURN` = 1, reset, make one legal move.
  - Response: `Turn` = 1 during the `Sel` cycle, `Turn` = 0 afterwards.
